// File: rtl/compositor_pkg.sv
// Shared types, constants and the per-channel blend rule for the layer compositor.
package compositor_pkg;

  // Width of one channel in the default-width pixel view.
  localparam int RGB_COLOR_W = 4;

  // Widest channel and alpha the blend helper accepts.
  localparam int BLEND_MAX_CW = 16;
  localparam int BLEND_MAX_AW = 8;

  // VGA syncs are active-low, so they idle high.
  localparam logic SYNC_IDLE_DEFAULT = 1'b1;

  typedef struct packed {
    logic [RGB_COLOR_W-1:0] r;
    logic [RGB_COLOR_W-1:0] g;
    logic [RGB_COLOR_W-1:0] b;
  } rgb_t;

  // Blends one channel of a layer over the accumulator.
  // Full alpha selects the layer and zero alpha keeps the accumulator.
  // Any other alpha mixes both with weights a and 2^alpha_w - a.
  // The weighted sum is below 2^(COLOR_W+ALPHA_W), so it cannot overflow.
  function automatic logic [BLEND_MAX_CW-1:0] blend(
    input logic [BLEND_MAX_CW-1:0] acc,
    input logic [BLEND_MAX_CW-1:0] lyr,
    input logic [BLEND_MAX_AW-1:0] alpha,
    input int unsigned             alpha_w
  );
    logic [31:0] a32;
    logic [31:0] full;
    logic [31:0] sum;
    a32  = {24'd0, alpha};
    full = 32'd1 << alpha_w;
    if (a32 == full - 32'd1) return lyr;
    if (a32 == 32'd0) return acc;
    sum = a32 * {16'd0, lyr} + (full - a32) * {16'd0, acc};
    sum = sum >> alpha_w;
    return sum[BLEND_MAX_CW-1:0];
  endfunction

endpackage

// File: rtl/blend_stage.sv
// One compositor pipeline stage.
// Blends layer IDX over the incoming accumulator.
// Registers the result together with the unconsumed layers, valid, syncs and the pixel's enable mask.
module blend_stage
  import compositor_pkg::*;
#(
  parameter int   NUM_LAYERS = 5,
  parameter int   COLOR_W    = 4,
  parameter int   ALPHA_W    = 1,
  parameter logic SYNC_IDLE  = SYNC_IDLE_DEFAULT,
  parameter int   IDX        = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vld_p0,
  input  logic                          hs_p0,
  input  logic                          vs_p0,
  input  logic [NUM_LAYERS-1:0]         mask_p0,
  input  logic [NUM_LAYERS*COLOR_W-1:0] lr_p0,
  input  logic [NUM_LAYERS*COLOR_W-1:0] lg_p0,
  input  logic [NUM_LAYERS*COLOR_W-1:0] lb_p0,
  input  logic [NUM_LAYERS*ALPHA_W-1:0] la_p0,
  input  logic [COLOR_W-1:0]            acc_r_p0,
  input  logic [COLOR_W-1:0]            acc_g_p0,
  input  logic [COLOR_W-1:0]            acc_b_p0,
  output logic                          vld_p1,
  output logic                          hs_p1,
  output logic                          vs_p1,
  output logic [NUM_LAYERS-1:0]         mask_p1,
  output logic [NUM_LAYERS*COLOR_W-1:0] lr_p1,
  output logic [NUM_LAYERS*COLOR_W-1:0] lg_p1,
  output logic [NUM_LAYERS*COLOR_W-1:0] lb_p1,
  output logic [NUM_LAYERS*ALPHA_W-1:0] la_p1,
  output logic [COLOR_W-1:0]            acc_r_p1,
  output logic [COLOR_W-1:0]            acc_g_p1,
  output logic [COLOR_W-1:0]            acc_b_p1
);

  logic [ALPHA_W-1:0] a_eff;
  logic [COLOR_W-1:0] mix_r;
  logic [COLOR_W-1:0] mix_g;
  logic [COLOR_W-1:0] mix_b;

  // A disabled layer or a blanking pixel contributes nothing.
  // The accumulator then rides through unchanged.
  assign a_eff = (vld_p0 && mask_p0[IDX]) ? la_p0[IDX*ALPHA_W +: ALPHA_W] : '0;

  assign mix_r = COLOR_W'(blend(BLEND_MAX_CW'(acc_r_p0), BLEND_MAX_CW'(lr_p0[IDX*COLOR_W +: COLOR_W]),
                                BLEND_MAX_AW'(a_eff), ALPHA_W));
  assign mix_g = COLOR_W'(blend(BLEND_MAX_CW'(acc_g_p0), BLEND_MAX_CW'(lg_p0[IDX*COLOR_W +: COLOR_W]),
                                BLEND_MAX_AW'(a_eff), ALPHA_W));
  assign mix_b = COLOR_W'(blend(BLEND_MAX_CW'(acc_b_p0), BLEND_MAX_CW'(lb_p0[IDX*COLOR_W +: COLOR_W]),
                                BLEND_MAX_AW'(a_eff), ALPHA_W));

  // ---- stage boundary: p0 -> p1 ----
  // Register the blended pixel and everything that travels with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      hs_p1    <= SYNC_IDLE;
      vs_p1    <= SYNC_IDLE;
      mask_p1  <= '0;
      lr_p1    <= '0;
      lg_p1    <= '0;
      lb_p1    <= '0;
      la_p1    <= '0;
      acc_r_p1 <= '0;
      acc_g_p1 <= '0;
      acc_b_p1 <= '0;
    end else begin
      vld_p1   <= vld_p0;
      hs_p1    <= hs_p0;
      vs_p1    <= vs_p0;
      mask_p1  <= mask_p0;
      lr_p1    <= lr_p0;
      lg_p1    <= lg_p0;
      lb_p1    <= lb_p0;
      la_p1    <= la_p0;
      acc_r_p1 <= mix_r;
      acc_g_p1 <= mix_g;
      acc_b_p1 <= mix_b;
    end
  end

endmodule

// File: rtl/layer_compositor_pipe.sv
// Pipelined NUM_LAYERS-layer compositor that drives the VGA outputs.
// Layers are blended bottom-to-top over a background colour, one stage per layer.
// Valid and syncs are delayed by the same NUM_LAYERS cycles.
module layer_compositor_pipe
  import compositor_pkg::*;
#(
  parameter int   NUM_LAYERS = 5,
  parameter int   COLOR_W    = 4,
  parameter int   ALPHA_W    = 1,
  parameter logic SYNC_IDLE  = SYNC_IDLE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic                          in_hsync,
  input  logic                          in_vsync,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_r,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_g,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_b,
  input  logic [NUM_LAYERS*ALPHA_W-1:0] layer_a,
  input  logic [NUM_LAYERS-1:0]         layer_en_cfg,
  input  logic [COLOR_W-1:0]            bg_r,
  input  logic [COLOR_W-1:0]            bg_g,
  input  logic [COLOR_W-1:0]            bg_b,
  output logic [COLOR_W-1:0]            out_r,
  output logic [COLOR_W-1:0]            out_g,
  output logic [COLOR_W-1:0]            out_b,
  output logic                          out_valid,
  output logic                          out_hsync,
  output logic                          out_vsync,
  output logic [NUM_LAYERS-1:0]         active_mask
);

  localparam int LCW = NUM_LAYERS * COLOR_W;
  localparam int LAW = NUM_LAYERS * ALPHA_W;

  logic                  vs_prev;
  logic                  vs_start;
  logic [NUM_LAYERS-1:0] mask_q;

  // Chain taps: index 0 is the raw input, index k+1 is the output of stage k.
  logic                  vld_c   [0:NUM_LAYERS];
  logic                  hs_c    [0:NUM_LAYERS];
  logic                  vs_c    [0:NUM_LAYERS];
  logic [NUM_LAYERS-1:0] mask_c  [0:NUM_LAYERS];
  logic [LCW-1:0]        lr_c    [0:NUM_LAYERS];
  logic [LCW-1:0]        lg_c    [0:NUM_LAYERS];
  logic [LCW-1:0]        lb_c    [0:NUM_LAYERS];
  logic [LAW-1:0]        la_c    [0:NUM_LAYERS];
  logic [COLOR_W-1:0]    acc_r_c [0:NUM_LAYERS];
  logic [COLOR_W-1:0]    acc_g_c [0:NUM_LAYERS];
  logic [COLOR_W-1:0]    acc_b_c [0:NUM_LAYERS];

  // The leading edge of the vsync pulse marks the start of a new frame.
  assign vs_start = (in_vsync != vs_prev) && (in_vsync == !SYNC_IDLE);

  // Track vsync and latch the requested enable mask at frame start.
  // The pixel entering on the edge cycle still sees the old mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev <= SYNC_IDLE;
      mask_q  <= '1;
    end else begin
      vs_prev <= in_vsync;
      if (vs_start) begin
        mask_q <= layer_en_cfg;
      end
    end
  end

  assign active_mask = mask_q;

  // Stage 0 sees the raw inputs, with the background as the starting accumulator.
  assign vld_c[0]   = in_valid;
  assign hs_c[0]    = in_hsync;
  assign vs_c[0]    = in_vsync;
  assign mask_c[0]  = mask_q;
  assign lr_c[0]    = layer_r;
  assign lg_c[0]    = layer_g;
  assign lb_c[0]    = layer_b;
  assign la_c[0]    = layer_a;
  assign acc_r_c[0] = bg_r;
  assign acc_g_c[0] = bg_g;
  assign acc_b_c[0] = bg_b;

  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_stage
    blend_stage #(
      .NUM_LAYERS (NUM_LAYERS),
      .COLOR_W    (COLOR_W),
      .ALPHA_W    (ALPHA_W),
      .SYNC_IDLE  (SYNC_IDLE),
      .IDX        (gi)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld_p0   (vld_c[gi]),
      .hs_p0    (hs_c[gi]),
      .vs_p0    (vs_c[gi]),
      .mask_p0  (mask_c[gi]),
      .lr_p0    (lr_c[gi]),
      .lg_p0    (lg_c[gi]),
      .lb_p0    (lb_c[gi]),
      .la_p0    (la_c[gi]),
      .acc_r_p0 (acc_r_c[gi]),
      .acc_g_p0 (acc_g_c[gi]),
      .acc_b_p0 (acc_b_c[gi]),
      .vld_p1   (vld_c[gi+1]),
      .hs_p1    (hs_c[gi+1]),
      .vs_p1    (vs_c[gi+1]),
      .mask_p1  (mask_c[gi+1]),
      .lr_p1    (lr_c[gi+1]),
      .lg_p1    (lg_c[gi+1]),
      .lb_p1    (lb_c[gi+1]),
      .la_p1    (la_c[gi+1]),
      .acc_r_p1 (acc_r_c[gi+1]),
      .acc_g_p1 (acc_g_c[gi+1]),
      .acc_b_p1 (acc_b_c[gi+1])
    );
  end

  // Blanking pixels are forced to black whatever the layers held.
  assign out_valid = vld_c[NUM_LAYERS];
  assign out_hsync = hs_c[NUM_LAYERS];
  assign out_vsync = vs_c[NUM_LAYERS];
  assign out_r     = vld_c[NUM_LAYERS] ? acc_r_c[NUM_LAYERS] : '0;
  assign out_g     = vld_c[NUM_LAYERS] ? acc_g_c[NUM_LAYERS] : '0;
  assign out_b     = vld_c[NUM_LAYERS] ? acc_b_c[NUM_LAYERS] : '0;

  // After the last stage every layer has been consumed, so the carried copies end here.
  logic unused_tail;
  assign unused_tail = ^{mask_c[NUM_LAYERS], lr_c[NUM_LAYERS], lg_c[NUM_LAYERS],
                         lb_c[NUM_LAYERS], la_c[NUM_LAYERS]};

endmodule

// File: tb/tb_layer_compositor_pipe.sv
// Bench for layer_compositor_pipe.
// Main instance: default 5 layers with 1-bit alpha.
// Second instance: 2 layers with 2-bit alpha.
module tb_layer_compositor_pipe;

  localparam int NL = 5;
  localparam int CW = 4;
  localparam int AW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              in_valid, in_hsync, in_vsync;
  logic [NL*CW-1:0]  layer_r, layer_g, layer_b;
  logic [NL*AW-1:0]  layer_a;
  logic [NL-1:0]     layer_en_cfg;
  logic [CW-1:0]     bg_r, bg_g, bg_b;
  logic [CW-1:0]     out_r, out_g, out_b;
  logic              out_valid, out_hsync, out_vsync;
  logic [NL-1:0]     active_mask;

  layer_compositor_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .layer_r(layer_r), .layer_g(layer_g), .layer_b(layer_b), .layer_a(layer_a),
    .layer_en_cfg(layer_en_cfg), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_valid(out_valid),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .active_mask(active_mask)
  );

  // Two-layer instance with 2-bit alpha.
  logic        d2_valid, d2_hsync, d2_vsync;
  logic [7:0]  d2_lr, d2_lg, d2_lb;
  logic [3:0]  d2_la;
  logic [1:0]  d2_cfg;
  logic [3:0]  d2_bg_r, d2_bg_g, d2_bg_b;
  logic [3:0]  d2_out_r, d2_out_g, d2_out_b;
  logic        d2_out_valid, d2_out_hsync, d2_out_vsync;
  logic [1:0]  d2_mask;

  layer_compositor_pipe #(.NUM_LAYERS(2), .COLOR_W(4), .ALPHA_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_valid), .in_hsync(d2_hsync), .in_vsync(d2_vsync),
    .layer_r(d2_lr), .layer_g(d2_lg), .layer_b(d2_lb), .layer_a(d2_la),
    .layer_en_cfg(d2_cfg), .bg_r(d2_bg_r), .bg_g(d2_bg_g), .bg_b(d2_bg_b),
    .out_r(d2_out_r), .out_g(d2_out_g), .out_b(d2_out_b), .out_valid(d2_out_valid),
    .out_hsync(d2_out_hsync), .out_vsync(d2_out_vsync), .active_mask(d2_mask)
  );

  int errors = 0;
  int checks = 0;

  // Expected {valid, hsync, vsync, r, g, b} per pixel, oldest first.
  logic [14:0]   exp_q[$];
  logic [NL-1:0] m_mask;
  logic          m_vs_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Colour of one pixel: the topmost enabled opaque layer, else the background.
  function automatic logic [11:0] model_rgb(input logic v, input logic [NL-1:0] m);
    if (!v) return 12'h000;
    for (int k = NL - 1; k >= 0; k--) begin
      if (m[k] && layer_a[k])
        return {layer_r[k*CW +: CW], layer_g[k*CW +: CW], layer_b[k*CW +: CW]};
    end
    return {bg_r, bg_g, bg_b};
  endfunction

  task automatic set_layer(input int k, input logic [3:0] r, input logic [3:0] g,
                           input logic [3:0] b, input logic a);
    layer_r[k*CW +: CW] = r;
    layer_g[k*CW +: CW] = g;
    layer_b[k*CW +: CW] = b;
    layer_a[k] = a;
  endtask

  // Pixels before release: blank, syncs idle.
  task automatic prefill();
    repeat (NL) exp_q.push_back({1'b0, 1'b1, 1'b1, 12'h000});
  endtask

  // Called at a falling edge with the new inputs already applied.
  // It checks the pixel now leaving the pipe, records the pixel now entering,
  // and then waits for the next falling edge.
  task automatic step(input string tag);
    logic [14:0] e;
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {17'd0, out_valid, out_hsync, out_vsync, out_r, out_g, out_b}, {17'd0, e});
    end
    chk("active_mask", {27'd0, active_mask}, {27'd0, m_mask});
    exp_q.push_back({in_valid, in_hsync, in_vsync, model_rgb(in_valid, m_mask)});
    if (in_vsync != m_vs_prev && in_vsync == 1'b0) m_mask = layer_en_cfg;
    m_vs_prev = in_vsync;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_hsync = 1'b1; in_vsync = 1'b1;
    layer_r = '0; layer_g = '0; layer_b = '0; layer_a = '0;
    layer_en_cfg = '1;
    bg_r = '0; bg_g = '0; bg_b = '0;
    d2_valid = 1'b0; d2_hsync = 1'b1; d2_vsync = 1'b1;
    d2_lr = '0; d2_lg = '0; d2_lb = '0; d2_la = '0; d2_cfg = '1;
    d2_bg_r = '0; d2_bg_g = '0; d2_bg_b = '0;
    m_mask = '1;
    m_vs_prev = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out", {17'd0, out_valid, out_hsync, out_vsync, out_r, out_g, out_b},
        {17'd0, 1'b0, 1'b1, 1'b1, 12'h000});
    chk("rst_mask", {27'd0, active_mask}, 32'h1F);
    rst_n = 1'b1;
    prefill();

    // Alignment: hsync toggles every 3 cycles, valid drops now and then, only bg shows
    bg_r = 4'h1; bg_g = 4'h2; bg_b = 4'h3;
    for (int i = 0; i < 18; i++) begin
      in_hsync = ((i / 3) % 2) != 0;
      in_valid = (i % 7) != 5;
      step("align");
    end
    in_valid = 1'b1; in_hsync = 1'b1;

    // Opaque stacking: layer3 covers layer0, then layer0 shows through
    set_layer(0, 4'h3, 4'h5, 4'h7, 1'b1);
    set_layer(3, 4'hA, 4'hB, 4'hC, 1'b1);
    repeat (6) step("stack_top");
    set_layer(3, 4'hA, 4'hB, 4'hC, 1'b0);
    repeat (6) step("stack_l0");

    // Blanking: every layer opaque white but valid low
    for (int k = 0; k < NL; k++) set_layer(k, 4'hF, 4'hF, 4'hF, 1'b1);
    in_valid = 1'b0;
    repeat (6) step("blank");
    in_valid = 1'b1;
    repeat (3) step("all_opaque");

    // Mask timing: request only layer0 mid-frame, it takes effect at the vsync fall
    for (int k = 0; k < NL; k++) set_layer(k, 4'h0, 4'h0, 4'h0, 1'b0);
    set_layer(0, 4'h3, 4'h3, 4'h3, 1'b1);
    set_layer(4, 4'hF, 4'hE, 4'hD, 1'b1);
    layer_en_cfg = 5'b00001;
    repeat (4) step("mask_hold");
    in_vsync = 1'b0;
    repeat (6) step("mask_edge");
    in_vsync = 1'b1;
    layer_en_cfg = 5'b11111;
    repeat (4) step("cfg_ignored");

    // Reset mid-stream: outputs clear at once, mask returns to all ones
    rst_n = 1'b0;
    #1;
    chk("midrst_out", {17'd0, out_valid, out_hsync, out_vsync, out_r, out_g, out_b},
        {17'd0, 1'b0, 1'b1, 1'b1, 12'h000});
    chk("midrst_mask", {27'd0, active_mask}, 32'h1F);
    exp_q.delete();
    m_mask = '1;
    m_vs_prev = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // A low vsync on the first cycle after release is a frame start
    layer_en_cfg = 5'b10000;
    in_vsync = 1'b0;
    rst_n = 1'b1;
    prefill();
    repeat (10) step("post_rst");
    in_vsync = 1'b1;
    in_valid = 1'b0;
    repeat (NL) step("drain");

    // Two-layer, 2-bit alpha: layer0 r=F g=4 b=0 a=3, layer1 r=0 g=C b=8
    d2_lr = {4'h0, 4'hF}; d2_lg = {4'hC, 4'h4}; d2_lb = {4'h8, 4'h0};
    d2_valid = 1'b1;
    d2_la = {2'd2, 2'd3};
    repeat (3) @(negedge clk);
    chk("a2_half", {d2_out_valid, d2_out_r, d2_out_g, d2_out_b}, {1'b1, 4'h7, 4'h8, 4'h4});
    d2_la = {2'd1, 2'd3};
    repeat (3) @(negedge clk);
    chk("a2_quarter", {d2_out_valid, d2_out_r, d2_out_g, d2_out_b}, {1'b1, 4'hB, 4'h6, 4'h2});
    d2_la = {2'd0, 2'd3};
    repeat (3) @(negedge clk);
    chk("a2_clear", {d2_out_valid, d2_out_r, d2_out_g, d2_out_b}, {1'b1, 4'hF, 4'h4, 4'h0});
    d2_la = {2'd3, 2'd3};
    repeat (3) @(negedge clk);
    chk("a2_opaque", {d2_out_valid, d2_out_r, d2_out_g, d2_out_b}, {1'b1, 4'h0, 4'hC, 4'h8});
    d2_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("a2_blank", {d2_out_valid, d2_out_r, d2_out_g, d2_out_b}, {1'b0, 4'h0, 4'h0, 4'h0});
    // Single valid pulse must come out exactly two cycles later
    d2_valid = 1'b1;
    @(negedge clk);
    d2_valid = 1'b0;
    chk("a2_lat1", {31'd0, d2_out_valid}, 32'd0);
    @(negedge clk);
    chk("a2_lat2", {31'd0, d2_out_valid}, 32'd1);
    @(negedge clk);
    chk("a2_lat3", {31'd0, d2_out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
